motor_bridge_driver: RTL and testbench

- Parametrised N-channel H-bridge driver: per-channel enable, direction and duty command drive the bridge input pin pairs (IN1/IN2 per motor) with registered PWM.
- Adds what the single switch-driven controller lacks: a programmable PWM prescaler, glitch-free duty updates, a dead-time on direction reversal, and per-channel overcurrent trip with a latched fault.
- Sits between the command source (switches, later a higher-level controller) and the board IN pins; consumes 12-bit current-sensor readings.

---
 rtl/motor_bridge_driver.sv | 130 +++++++++++++
 tb/tb_motor_bridge_driver.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/motor_bridge_driver.sv
// N-channel H-bridge driver: shared prescaled PWM timebase, per-channel
// run/dead-time/fault sequencing with registered IN1/IN2 outputs.
module motor_bridge_driver #(
  parameter int          N_CH     = 2,
  parameter int          DUTY_W   = 8,
  parameter int          PRESCALE = 100,
  parameter int          DEAD_CYC = 1000,
  parameter logic [11:0] OC_LIMIT = 12'hC00,
  parameter int          OC_FILT  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_CH-1:0]          en,
  input  logic [N_CH-1:0]          dir,
  input  logic [N_CH*DUTY_W-1:0]   duty,
  input  logic [N_CH*12-1:0]       current,
  input  logic                     fault_clr,
  output logic [2*N_CH-1:0]        IN,
  output logic [N_CH-1:0]          fault,
  output logic                     period_start
);

  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int DC_W  = $clog2(DEAD_CYC + 1);
  localparam int FC_W  = $clog2(OC_FILT + 1);
  localparam logic [DUTY_W-1:0] CNT_MAX = DUTY_W'((1 << DUTY_W) - 2);

  typedef enum logic [1:0] {IDLE, RUN, DEAD, FLT} state_t;

  logic [PRE_W-1:0]  pre;
  logic [DUTY_W-1:0] cnt;
  logic              started;
  logic              tick;
  logic              boundary;

  assign tick     = (pre == PRE_W'(PRESCALE - 1));
  // The first tick after reset opens a full period instead of advancing.
  assign boundary = tick && (!started || cnt == CNT_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre          <= '0;
      cnt          <= '0;
      started      <= 1'b0;
      period_start <= 1'b0;
    end else begin
      period_start <= boundary;
      if (tick) pre <= '0;
      else      pre <= pre + PRE_W'(1);
      if (tick) begin
        started <= 1'b1;
        if (boundary) cnt <= '0;
        else          cnt <= cnt + DUTY_W'(1);
      end
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    state_t            st;
    logic              ldir;
    logic [DUTY_W-1:0] dl;
    logic [DC_W-1:0]   dc;
    logic [FC_W-1:0]   fc;
    logic [1:0]        in_q;
    logic              flt_q;
    logic              over;
    logic              trip;
    logic              pwm;

    assign over = (current[k*12 +: 12] >= OC_LIMIT);
    assign trip = over && (fc >= FC_W'(OC_FILT - 1));
    assign pwm  = (dl > cnt);

    // in_q is {IN2, IN1}; both halves come from one latched direction so
    // they can never be high together.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        st    <= IDLE;
        ldir  <= 1'b1;
        dl    <= '0;
        dc    <= '0;
        fc    <= '0;
        in_q  <= 2'b00;
        flt_q <= 1'b0;
      end else begin
        if (boundary) dl <= duty[k*DUTY_W +: DUTY_W];
        if (!over)                       fc <= '0;
        else if (fc != FC_W'(OC_FILT))   fc <= fc + FC_W'(1);
        in_q  <= 2'b00;
        flt_q <= 1'b0;
        if (trip) begin
          st    <= FLT;
          flt_q <= 1'b1;
        end else begin
          case (st)
            IDLE: if (en[k]) begin
              st   <= RUN;
              ldir <= dir[k];
              in_q <= dir[k] ? {1'b0, pwm} : {pwm, 1'b0};
            end
            RUN: begin
              if (!en[k]) st <= IDLE;
              else if (dir[k] != ldir) begin
                st <= DEAD;
                dc <= DC_W'(DEAD_CYC);
              end else in_q <= ldir ? {1'b0, pwm} : {pwm, 1'b0};
            end
            DEAD: begin
              if (!en[k]) st <= IDLE;
              else if (dc <= DC_W'(1)) begin
                st   <= RUN;
                dc   <= '0;
                ldir <= dir[k];
                in_q <= dir[k] ? {1'b0, pwm} : {pwm, 1'b0};
              end else dc <= dc - DC_W'(1);
            end
            FLT: begin
              if (fault_clr && !over) st <= IDLE;
              else                    flt_q <= 1'b1;
            end
          endcase
        end
      end
    end

    assign IN[2*k +: 2] = in_q;
    assign fault[k]     = flt_q;
  end

endmodule

// File: tb/tb_motor_bridge_driver.sv
// Bench for motor_bridge_driver: time-based reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_motor_bridge_driver;
  localparam int          NCH  = 2;
  localparam int          DW   = 4;
  localparam int          P    = 2;
  localparam int          DC   = 8;
  localparam logic [11:0] LIM  = 12'h800;
  localparam int          FILT = 4;
  localparam int          NPER = (1 << DW) - 1;

  localparam int M_IDLE = 0, M_RUN = 1, M_DEAD = 2, M_FAULT = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  en = 2'b00;
  logic [1:0]  dir = 2'b11;
  logic [7:0]  duty = 8'h00;
  logic [23:0] current = 24'h0;
  logic        fault_clr = 1'b0;
  logic [3:0]  IN;
  logic [1:0]  fault;
  logic        period_start;

  motor_bridge_driver #(
    .N_CH(NCH), .DUTY_W(DW), .PRESCALE(P), .DEAD_CYC(DC),
    .OC_LIMIT(LIM), .OC_FILT(FILT)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .dir(dir), .duty(duty),
    .current(current), .fault_clr(fault_clr), .IN(IN), .fault(fault),
    .period_start(period_start)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: timebase from the edge count since reset release.
  int   e = 0;
  int   mode [NCH];
  logic ldir_m [NCH];
  int   dead_end [NCH];
  int   overrun [NCH];
  int   mdl [NCH];
  int   m_pre;
  logic m_bnd, m_pwm, m_over;
  logic [3:0] x_in = 4'h0;
  logic [1:0] x_fault = 2'b00;
  logic       x_ps = 1'b0;

  function automatic int cnt_after(input int ed);
    int j;
    j = ed / P;
    return (j == 0) ? 0 : (j - 1) % NPER;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      e = 0; x_in = 4'h0; x_fault = 2'b00; x_ps = 1'b0;
      for (int k = 0; k < NCH; k++) begin
        mode[k] = M_IDLE; ldir_m[k] = 1'b1; dead_end[k] = 0;
        overrun[k] = 0; mdl[k] = 0;
      end
    end else begin
      e = e + 1;
      m_pre = cnt_after(e - 1);
      m_bnd = ((e % P) == 0) && (cnt_after(e) == 0);
      for (int k = 0; k < NCH; k++) begin
        m_pwm = (mdl[k] > m_pre);
        if (m_bnd) mdl[k] = int'(duty[k*4 +: 4]);
        m_over = (current[k*12 +: 12] >= LIM);
        overrun[k] = m_over ? overrun[k] + 1 : 0;
        if (overrun[k] >= FILT) mode[k] = M_FAULT;
        else case (mode[k])
          M_IDLE: if (en[k]) begin mode[k] = M_RUN; ldir_m[k] = dir[k]; end
          M_RUN: begin
            if (!en[k]) mode[k] = M_IDLE;
            else if (dir[k] != ldir_m[k]) begin mode[k] = M_DEAD; dead_end[k] = e + DC; end
          end
          M_DEAD: begin
            if (!en[k]) mode[k] = M_IDLE;
            else if (e == dead_end[k]) begin mode[k] = M_RUN; ldir_m[k] = dir[k]; end
          end
          default: if (fault_clr && !m_over) mode[k] = M_IDLE;
        endcase
        x_in[2*k +: 2] = (mode[k] == M_RUN) ? (ldir_m[k] ? {1'b0, m_pwm} : {m_pwm, 1'b0}) : 2'b00;
        x_fault[k] = (mode[k] == M_FAULT);
      end
      x_ps = m_bnd;
    end
  end

  always @(negedge clk) begin
    chk("in", int'(IN), int'(x_in));
    chk("fault", int'(fault), int'(x_fault));
    chk("period_start", int'(period_start), int'(x_ps));
    for (int k = 0; k < NCH; k++) chk("no_shoot_through", int'(IN[2*k] & IN[2*k+1]), 0);
  end

  task automatic sync_ps();
    int found;
    found = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (period_start) begin found = 1; break; end
    end
    chk("sync_ps_timeout", found, 1);
  endtask

  task automatic count30(input int mid, input logic [3:0] md, output int h0, output int h1);
    h0 = 0; h1 = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (i == mid) duty[3:0] = md;
      h0 += int'(IN[0]);
      h1 += int'(IN[1]);
    end
  endtask

  int sweep [3] = '{0, 5, 15};
  int h0, h1, zeros, got, n;

  initial begin
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_in", int'(IN), 0);
    chk("reset_fault", int'(fault), 0);
    chk("reset_ps", int'(period_start), 0);
    reset = 1'b0;
    en[0] = 1'b1;

    for (int s = 0; s < 3; s++) begin
      duty[3:0] = 4'(sweep[s]);
      sync_ps();
      count30(0, 4'h0, h0, h1);
      chk("sweep_in1_high", h0, 2 * sweep[s]);
      chk("sweep_in2_high", h1, 0);
      chk("sweep_period_30", int'(period_start), 1);
    end

    duty[3:0] = 4'd5;
    sync_ps();
    count30(6, 4'd10, h0, h1);
    chk("midchange_cur_period", h0, 10);
    chk("midchange_ps", int'(period_start), 1);
    count30(0, 4'h0, h0, h1);
    chk("midchange_next_period", h0, 20);

    duty[3:0] = 4'd15;
    sync_ps();
    repeat (2) @(negedge clk);
    chk("fwd_full", int'(IN[1:0]), 1);
    dir[0] = 1'b0;
    zeros = 0; got = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (IN[1:0] == 2'b00) zeros++;
      else begin got = int'(IN[1:0]); break; end
    end
    chk("dead_len", zeros, 8);
    chk("rev_drive", got, 2);

    en[1] = 1'b1; dir[1] = 1'b0; duty[7:4] = 4'd15;
    sync_ps();
    repeat (2) @(negedge clk);
    chk("ch1_run", int'(IN[3:2]), 2);
    current[23:12] = 12'h800;
    repeat (3) @(negedge clk);
    current[23:12] = 12'h100;
    repeat (3) @(negedge clk);
    chk("oc_short_no_trip", int'(fault[1]), 0);
    current[23:12] = 12'h900;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk("oc_trip_timing", int'(fault[1]), (i == 4) ? 1 : 0);
    end
    chk("oc_in_off", int'(IN[3:2]), 0);
    chk("oc_ch0_fault", int'(fault[0]), 0);
    chk("oc_ch0_drive", int'(IN[1:0]), 2);

    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    chk("clr_ignored_high", int'(fault[1]), 1);
    current[23:12] = 12'h100;
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    chk("clr_fault_low", int'(fault[1]), 0);
    chk("clr_idle_off", int'(IN[3:2]), 0);
    @(negedge clk);
    chk("clr_resume", int'(IN[3:2]), 2);

    current[23:12] = 12'h900;
    repeat (5) @(negedge clk);
    chk("pre_reset_fault", int'(fault[1]), 1);
    dir[0] = 1'b1;
    repeat (3) @(negedge clk);
    chk("dead_before_reset", int'(IN[1:0]), 0);
    #2 reset = 1'b1;
    #1;
    chk("async_in", int'(IN), 0);
    chk("async_fault", int'(fault), 0);
    current = 24'h0;
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    n = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (period_start) begin n = i; break; end
    end
    chk("ps_first_tick", n, 2);
    repeat (40) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
